// File: rtl/gsim_sweep_ctrl_if.sv
// Update-engine handshake for the Gauss-Seidel sweep sequencer.
// The sequencer (master) requests a row update; the engine (slave)
// acknowledges with a one-cycle pulse and the |delta| of that row.
interface gsim_sweep_ctrl_if #(
    parameter int ROW_W   = 4,
    parameter int DELTA_W = 32
);
    logic               upd_req;
    logic [ROW_W-1:0]   upd_row;
    logic               upd_init;
    logic               upd_ack;
    logic [DELTA_W-1:0] upd_delta;

    modport master (
        output upd_req,
        output upd_row,
        output upd_init,
        input  upd_ack,
        input  upd_delta
    );

    modport slave (
        input  upd_req,
        input  upd_row,
        input  upd_init,
        output upd_ack,
        output upd_delta
    );
endinterface

// File: rtl/gsim_sweep_ctrl.sv
// Sequencer for the Gauss-Seidel row-update datapath of the banded solver.
// Counts the b-vector load, issues forward sweeps of row updates, tracks the
// per-sweep maximum |delta|, stops on tolerance or on the sweep cap, then
// streams the solution words out of the x buffer in index order.
module gsim_sweep_ctrl #(
    parameter int N        = 16,
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 50,
    parameter int MIN_ITER = 2,
    parameter int DELTA_W  = 32,
    parameter int TOL      = 16,
    localparam int ROW_W   = $clog2(N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_en,
    output logic              b_wr_en,
    output logic [ROW_W-1:0]  b_wr_addr,
    gsim_sweep_ctrl_if.master upd,
    output logic [ROW_W-1:0]  x_rd_addr,
    input  logic [31:0]       x_rd_data,
    output logic [31:0]       x_out,
    output logic              out_valid,
    output logic              busy,
    output logic              converged,
    output logic [ITER_W-1:0] iter_count
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SWEEP,
        DRAIN
    } state_t;

    localparam logic [ROW_W-1:0]   LAST_ROW = ROW_W'(N - 1);
    localparam logic [ITER_W-1:0]  MIN_K    = ITER_W'(MIN_ITER);
    localparam logic [ITER_W-1:0]  MAX_K    = ITER_W'(MAX_ITER);
    localparam logic [DELTA_W-1:0] TOL_D    = DELTA_W'(TOL);

    state_t             state;
    logic [ROW_W-1:0]   ld_cnt;
    logic [DELTA_W-1:0] max_d;
    logic               addr_vld;
    logic               data_vld;
    logic [DELTA_W-1:0] max_next;
    logic [ITER_W-1:0]  iter_next;

    assign b_wr_en   = in_en && (state == LOAD);
    assign b_wr_addr = ld_cnt;
    assign busy      = (state != IDLE);

    // Running max including the row being acknowledged, and the sweep count it would complete
    always_comb begin
        max_next  = (upd.upd_delta > max_d) ? upd.upd_delta : max_d;
        iter_next = iter_count + ITER_W'(1);
    end

    // Main sequencer: load count, sweep/row stepping, termination test and drain pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ld_cnt       <= '0;
            max_d        <= '0;
            upd.upd_req  <= 1'b0;
            upd.upd_row  <= '0;
            upd.upd_init <= 1'b0;
            x_rd_addr    <= '0;
            addr_vld     <= 1'b0;
            data_vld     <= 1'b0;
            x_out        <= '0;
            out_valid    <= 1'b0;
            converged    <= 1'b0;
            iter_count   <= '0;
        end else begin
            data_vld  <= addr_vld;
            out_valid <= data_vld;
            if (data_vld) begin
                x_out <= x_rd_data;
            end
            case (state)
                IDLE: begin
                    state      <= LOAD;
                    ld_cnt     <= '0;
                    converged  <= 1'b0;
                    iter_count <= '0;
                end
                LOAD: begin
                    if (in_en) begin
                        if (ld_cnt == LAST_ROW) begin
                            ld_cnt       <= '0;
                            state        <= SWEEP;
                            upd.upd_req  <= 1'b1;
                            upd.upd_row  <= '0;
                            upd.upd_init <= 1'b1;
                            max_d        <= '0;
                        end else begin
                            ld_cnt <= ld_cnt + ROW_W'(1);
                        end
                    end
                end
                SWEEP: begin
                    if (upd.upd_req && upd.upd_ack) begin
                        if (upd.upd_row != LAST_ROW) begin
                            upd.upd_row <= upd.upd_row + ROW_W'(1);
                            max_d       <= max_next;
                        end else begin
                            iter_count   <= iter_next;
                            upd.upd_init <= 1'b0;
                            if ((iter_next >= MIN_K) && (max_next <= TOL_D)) begin
                                converged   <= 1'b1;
                                upd.upd_req <= 1'b0;
                                max_d       <= max_next;
                                state       <= DRAIN;
                                x_rd_addr   <= '0;
                                addr_vld    <= 1'b1;
                            end else if (iter_next == MAX_K) begin
                                upd.upd_req <= 1'b0;
                                max_d       <= max_next;
                                state       <= DRAIN;
                                x_rd_addr   <= '0;
                                addr_vld    <= 1'b1;
                            end else begin
                                max_d       <= '0;
                                upd.upd_row <= '0;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (addr_vld) begin
                        if (x_rd_addr == LAST_ROW) begin
                            addr_vld <= 1'b0;
                        end else begin
                            x_rd_addr <= x_rd_addr + ROW_W'(1);
                        end
                    end
                    if (out_valid && !data_vld) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gsim_sweep_ctrl.sv
// Self-checking bench for gsim_sweep_ctrl: a run-level reference model predicts
// the number of sweeps, the convergence flag, the request sequence and the
// output burst, and a negedge process compares the DUT against it every cycle.
module tb_gsim_sweep_ctrl;

    localparam int N        = 16;
    localparam int MAX_ITER = 50;
    localparam int MIN_ITER = 2;
    localparam int TOL      = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_en = 1'b0;
    logic        b_wr_en;
    logic [3:0]  b_wr_addr;
    logic [3:0]  x_rd_addr;
    logic [31:0] x_rd_data = '0;
    logic [31:0] x_out;
    logic        out_valid;
    logic        busy;
    logic        converged;
    logic [7:0]  iter_count;

    gsim_sweep_ctrl_if #(.ROW_W(4), .DELTA_W(32)) upd_bus ();

    gsim_sweep_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .in_en      (in_en),
        .b_wr_en    (b_wr_en),
        .b_wr_addr  (b_wr_addr),
        .upd        (upd_bus),
        .x_rd_addr  (x_rd_addr),
        .x_rd_data  (x_rd_data),
        .x_out      (x_out),
        .out_valid  (out_valid),
        .busy       (busy),
        .converged  (converged),
        .iter_count (iter_count)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    logic [31:0] dtab [MAX_ITER][N];
    logic [31:0] mem [N];
    int exp_k;
    bit exp_conv;
    int lit_k;
    int lit_conv;

    int wr_idx;
    int req_idx;
    int drain_cnt;
    int wait_cnt;
    bit load_done;
    bit tracking = 1'b0;
    bit run_done;
    bit delay_mode;

    int checks = 0;
    int errors = 0;

    // x buffer: data appears one cycle after the address
    always @(posedge clk) x_rd_data <= mem[x_rd_addr];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic check_reset_zero();
        checkOutput("rst_upd_req", 64'(upd_bus.upd_req), 64'd0);
        checkOutput("rst_upd_row", 64'(upd_bus.upd_row), 64'd0);
        checkOutput("rst_upd_init", 64'(upd_bus.upd_init), 64'd0);
        checkOutput("rst_x_out", 64'(x_out), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_converged", 64'(converged), 64'd0);
        checkOutput("rst_iter_count", 64'(iter_count), 64'd0);
        checkOutput("rst_b_wr_en", 64'(b_wr_en), 64'd0);
        checkOutput("rst_b_wr_addr", 64'(b_wr_addr), 64'd0);
        checkOutput("rst_x_rd_addr", 64'(x_rd_addr), 64'd0);
    endtask

    // Fill the delta table for a run and derive its outcome from the stopping rules
    task automatic build_model(input int mode);
        logic [31:0] m;
        int sel;
        int hot;
        for (int s = 0; s < MAX_ITER; s++) begin
            sel = $urandom_range(0, 3);
            hot = $urandom_range(0, N - 1);
            for (int r = 0; r < N; r++) begin
                case (mode)
                    0: dtab[s][r] = 32'd1000;
                    1: dtab[s][r] = (s < 3) ? 32'd1000 : 32'($urandom_range(0, 16));
                    2: dtab[s][r] = 32'd0;
                    3: dtab[s][r] = (s < 3 && r == N - 1) ? 32'd17 : 32'd0;
                    default: begin
                        if (sel == 0)      dtab[s][r] = 32'($urandom_range(0, 16));
                        else if (sel == 1) dtab[s][r] = (r == hot) ? ((s % 2 == 0) ? 32'd17 : 32'hFFFF_FFFF) : 32'd0;
                        else               dtab[s][r] = 32'($urandom_range(0, 40));
                    end
                endcase
            end
        end
        exp_k = 0;
        exp_conv = 1'b0;
        for (int s = 0; s < MAX_ITER; s++) begin
            m = 0;
            for (int r = 0; r < N; r++) begin
                if (dtab[s][r] > m) m = dtab[s][r];
            end
            exp_k = s + 1;
            if (exp_k >= MIN_ITER && m <= TOL) begin
                exp_conv = 1'b1;
                break;
            end
        end
    endtask

    // Per-cycle comparison against the model plus the update engine responder
    always @(negedge clk) begin
        bit exp_wr;
        bit exp_req;
        bit exp_ov;
        if (tracking && !reset) begin
            if (load_done && req_idx == N * exp_k) drain_cnt++;
            exp_wr = in_en && (wr_idx < N);
            checkOutput("b_wr_en", 64'(b_wr_en), 64'(exp_wr));
            if (exp_wr) begin
                checkOutput("b_wr_addr", 64'(b_wr_addr), 64'(wr_idx));
                wr_idx++;
            end
            if (!load_done) begin
                if (busy) begin
                    checkOutput("load_upd_req", 64'(upd_bus.upd_req), 64'd0);
                    checkOutput("load_converged", 64'(converged), 64'd0);
                    checkOutput("load_iter_count", 64'(iter_count), 64'd0);
                end
            end else begin
                exp_req = (req_idx < N * exp_k);
                checkOutput("upd_req", 64'(upd_bus.upd_req), 64'(exp_req));
                if (upd_bus.upd_req && exp_req) begin
                    checkOutput("upd_row", 64'(upd_bus.upd_row), 64'(req_idx % N));
                    checkOutput("upd_init", 64'(upd_bus.upd_init), 64'(req_idx < N));
                end
                checkOutput("iter_count", 64'(iter_count), 64'(req_idx / N));
                checkOutput("converged", 64'(converged), 64'(!exp_req && exp_conv));
                if (exp_req) begin
                    checkOutput("busy_sweep", 64'(busy), 64'd1);
                    checkOutput("out_valid_sweep", 64'(out_valid), 64'd0);
                end else begin
                    exp_ov = (drain_cnt >= 3) && (drain_cnt <= N + 2);
                    checkOutput("busy_drain", 64'(busy), 64'(drain_cnt <= N + 2));
                    checkOutput("out_valid", 64'(out_valid), 64'(exp_ov));
                    if (exp_ov) checkOutput("x_out", 64'(x_out), 64'(mem[drain_cnt - 3]));
                    if (drain_cnt >= 1 && drain_cnt <= N)
                        checkOutput("x_rd_addr", 64'(x_rd_addr), 64'(drain_cnt - 1));
                    if (drain_cnt == N + 3) begin
                        if (lit_k >= 0) begin
                            checkOutput("lit_iter_count", 64'(iter_count), 64'(lit_k));
                            checkOutput("lit_model_k", 64'(exp_k), 64'(lit_k));
                            checkOutput("lit_converged", 64'(converged), 64'(lit_conv));
                            checkOutput("lit_model_conv", 64'(exp_conv), 64'(lit_conv));
                        end
                        run_done = 1'b1;
                        tracking = 1'b0;
                    end
                end
            end
            if (wr_idx == N) load_done = 1'b1;
            if (load_done && upd_bus.upd_req && req_idx < N * exp_k) begin
                if (wait_cnt == 0) begin
                    upd_bus.upd_ack   = 1'b1;
                    upd_bus.upd_delta = dtab[req_idx / N][req_idx % N];
                    req_idx++;
                    wait_cnt = delay_mode ? $urandom_range(0, 2) : 0;
                end else begin
                    upd_bus.upd_ack   = 1'b0;
                    upd_bus.upd_delta = $urandom;
                    wait_cnt--;
                end
            end else if (!upd_bus.upd_req) begin
                upd_bus.upd_ack   = ($urandom_range(0, 3) == 0);
                upd_bus.upd_delta = $urandom;
            end else begin
                upd_bus.upd_ack = 1'b0;
            end
        end else begin
            upd_bus.upd_ack   = 1'b0;
            upd_bus.upd_delta = '0;
        end
    end

    // One run: called at posedge+1 with the DUT in LOAD; returns the same way
    task automatic applyStimulus(input int mode, input bit delay, input bit mem_index,
                                 input int abort_mode, input int k_lit, input int conv_lit);
        int gap;
        int cyc;
        build_model(mode);
        for (int i = 0; i < N; i++) mem[i] = mem_index ? 32'(i) : $urandom;
        wr_idx = 0;
        req_idx = 0;
        drain_cnt = 0;
        wait_cnt = 0;
        load_done = 1'b0;
        run_done = 1'b0;
        delay_mode = delay;
        lit_k = k_lit;
        lit_conv = conv_lit;
        tracking = 1'b1;
        checkOutput("busy_in_load", 64'(busy), 64'd1);
        for (int i = 0; i < N; i++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            in_en = 1'b1;
            @(posedge clk);
            #1;
            in_en = 1'b0;
        end
        checkOutput("sweep_entry_req", 64'(upd_bus.upd_req), 64'd1);
        checkOutput("sweep_entry_row", 64'(upd_bus.upd_row), 64'd0);
        checkOutput("sweep_entry_init", 64'(upd_bus.upd_init), 64'd1);
        cyc = 0;
        while (!run_done && cyc < MAX_ITER * N * 3 + 200) begin
            if (abort_mode == 1 && req_idx >= 40) break;
            if (abort_mode == 2 && drain_cnt >= 8) break;
            in_en = upd_bus.upd_req && ($urandom_range(0, 3) == 0);
            @(posedge clk);
            #1;
            cyc++;
        end
        in_en = 1'b0;
        if (abort_mode != 0 || !run_done) begin
            if (abort_mode == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL run_timeout: got running expected done after %0d cycles", cyc);
            end
            #2;
            tracking = 1'b0;
            reset = 1'b1;
            #1;
            if (abort_mode != 0) check_reset_zero();
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    // Test sequence: fixed-outcome runs, random runs, then mid-run resets
    initial begin
        upd_bus.upd_ack = 1'b0;
        upd_bus.upd_delta = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_zero();
        reset = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(0, 1'b0, 1'b0, 0, 50, 0);
        applyStimulus(1, 1'b1, 1'b0, 0, 4, 1);
        applyStimulus(2, 1'b1, 1'b0, 0, 2, 1);
        applyStimulus(3, 1'b0, 1'b0, 0, 4, 1);
        for (int i = 0; i < 3; i++) applyStimulus(4, 1'b1, 1'b0, 0, -1, 0);
        applyStimulus(0, 1'b0, 1'b0, 1, -1, 0);
        applyStimulus(2, 1'b1, 1'b0, 2, -1, 0);
        applyStimulus(4, 1'b1, 1'b1, 0, -1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
